// File: rtl/skid_buffer.sv
// skid_buffer: two-entry ready/valid register slice (output + skid register).
// All outputs come straight from flops, so the slice breaks every timing path.
`default_nettype none

module skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   odr;
  logic [W-1:0]   sdr;
  logic           odr_we;
  logic           sdr_we;
  logic           odr_from_sdr;
  logic           odr_en;
  logic           sdr_en;

  always_comb begin
    state_nxt    = state;
    odr_we       = 1'b0;
    sdr_we       = 1'b0;
    odr_from_sdr = 1'b0;
    case (state)
      EMPTY: begin
        if (in_vld) begin
          odr_we    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_vld && out_rdy) begin
          odr_we = 1'b1;
        end else if (in_vld) begin
          sdr_we    = 1'b1;
          state_nxt = FULL;
        end else if (out_rdy) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_rdy is low here, so in_dat is never looked at
        if (out_rdy) begin
          odr_we       = 1'b1;
          odr_from_sdr = 1'b1;
          state_nxt    = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Data registers carry no reset, so loads are blocked while reset is held
  assign odr_en = odr_we & ~arst;
  assign sdr_en = sdr_we & ~arst;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= EMPTY;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      in_rdy  <= (state_nxt != FULL);
      out_vld <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (odr_en) begin
      odr <= odr_from_sdr ? sdr : in_dat;
    end
    if (sdr_en) begin
      sdr <= in_dat;
    end
  end

  assign out_dat = odr;

endmodule

`default_nettype wire

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed vector table, reset-while-full sequence and a
// randomized scoreboard run against a queue model of the two-entry slice.
`default_nettype none

module tb_skid_buffer;

  localparam int W = 8;

  logic         clk;
  logic         arst;
  logic         in_vld;
  logic [W-1:0] in_dat;
  logic         in_rdy;
  logic         out_vld;
  logic [W-1:0] out_dat;
  logic         out_rdy;

  int n_vec;
  int n_err;

  skid_buffer #(.W(W)) dut (
    .clk     (clk),
    .arst    (arst),
    .in_vld  (in_vld),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
    logic         ordy;
    logic         e_ovld;
    logic         e_irdy;
    logic         chk_dat;
    logic [W-1:0] e_dat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic v, input logic [W-1:0] d, input logic r,
                      input logic eo, input logic ei, input logic cd, input logic [W-1:0] ed);
    vec_t x;
    x.vld = v; x.dat = d; x.ordy = r;
    x.e_ovld = eo; x.e_irdy = ei; x.chk_dat = cd; x.e_dat = ed;
    vt.push_back(x);
  endtask

  // Drive inputs, let one edge happen, sample 1 time unit later
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_vld  = v;
    in_dat  = d;
    out_rdy = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic         ix;
    logic         ox;
    logic         irdy_early;

    n_vec = 0;
    n_err = 0;

    // Reset with in_vld active and clock running: stays EMPTY
    arst = 1'b1; in_vld = 1'b1; in_dat = 8'hEE; out_rdy = 1'b0;
    #1;
    check("rst_out_vld", {7'd0, out_vld}, 8'd0);
    check("rst_in_rdy",  {7'd0, in_rdy},  8'd1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_out_vld", {7'd0, out_vld}, 8'd0);
    check("rst_hold_in_rdy",  {7'd0, in_rdy},  8'd1);
    arst = 1'b0; in_vld = 1'b0;

    //    vld  dat    ordy  ovld irdy chk  exp
    addv(1, 8'hA5, 1,    1,   1,   1,  8'hA5);  // first payload after reset
    addv(0, 8'h00, 1,    0,   1,   1,  8'hA5);  // drain, ODR unchanged
    addv(1, 8'h01, 1,    1,   1,   1,  8'h01);  // back-to-back stream
    addv(1, 8'h02, 1,    1,   1,   1,  8'h02);
    addv(1, 8'h03, 1,    1,   1,   1,  8'h03);
    addv(1, 8'h04, 1,    1,   1,   1,  8'h04);
    addv(0, 8'h00, 1,    0,   1,   1,  8'h04);
    addv(1, 8'h11, 0,    1,   1,   1,  8'h11);  // fill to FULL
    addv(1, 8'h22, 0,    1,   0,   1,  8'h11);
    addv(1, 8'h33, 0,    1,   0,   1,  8'h11);  // blocked input ignored
    addv(1, 8'h33, 0,    1,   0,   1,  8'h11);
    addv(1, 8'h33, 0,    1,   0,   1,  8'h11);
    addv(1, 8'h33, 1,    1,   1,   1,  8'h22);  // SDR -> ODR, 0x33 not taken
    addv(1, 8'h33, 1,    1,   1,   1,  8'h33);  // 0x33 accepted now
    addv(0, 8'h00, 1,    0,   1,   1,  8'h33);
    addv(1, 8'h5A, 0,    1,   1,   1,  8'h5A);  // BUSY hold
    addv(0, 8'h00, 0,    1,   1,   1,  8'h5A);
    addv(0, 8'h00, 1,    0,   1,   1,  8'h5A);
    addv(0, 8'hFF, 1,    0,   1,   1,  8'h5A);  // out_rdy while empty: no effect
    addv(1, 8'h66, 0,    1,   1,   1,  8'h66);  // FULL then drain without input
    addv(1, 8'h77, 0,    1,   0,   1,  8'h66);
    addv(0, 8'h00, 1,    1,   1,   1,  8'h77);
    addv(0, 8'h00, 1,    0,   1,   1,  8'h77);

    foreach (vt[i]) begin
      step(vt[i].vld, vt[i].dat, vt[i].ordy);
      check($sformatf("v%0d_out_vld", i), {7'd0, out_vld}, {7'd0, vt[i].e_ovld});
      check($sformatf("v%0d_in_rdy", i),  {7'd0, in_rdy},  {7'd0, vt[i].e_irdy});
      if (vt[i].chk_dat) check($sformatf("v%0d_out_dat", i), out_dat, vt[i].e_dat);
    end

    // Asynchronous reset mid-cycle while FULL
    step(1, 8'h81, 0);
    step(1, 8'h82, 0);
    check("pre_rst_full_in_rdy", {7'd0, in_rdy}, 8'd0);
    #2;
    arst = 1'b1;
    #1;
    check("arst_async_out_vld", {7'd0, out_vld}, 8'd0);
    check("arst_async_in_rdy",  {7'd0, in_rdy},  8'd1);
    @(posedge clk);
    #1;
    arst = 1'b0;
    step(1, 8'h90, 0);
    check("post_rst_out_vld", {7'd0, out_vld}, 8'd1);
    check("post_rst_out_dat", out_dat, 8'h90);
    step(1, 8'h91, 1);
    check("post_rst_second", out_dat, 8'h91);
    step(0, 8'h00, 1);
    check("post_rst_empty", {7'd0, out_vld}, 8'd0);

    // Random traffic against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_vld  = ($urandom_range(0, 9) < 7);
      in_dat  = W'($urandom);
      out_rdy = ($urandom_range(0, 1) == 1);
      irdy_early = in_rdy;
      @(negedge clk);
      if (in_rdy !== irdy_early) check("rnd_in_rdy_stable", {7'd0, in_rdy}, {7'd0, irdy_early});
      ix = in_vld & in_rdy;
      ox = out_vld & out_rdy;
      if (ox) begin
        if (q.size() == 0) check("rnd_spurious_out", 8'd1, 8'd0);
        else check("rnd_out_dat", out_dat, q[0]);
      end
      // Mid-cycle out_rdy flip must not reach in_rdy
      out_rdy = ~out_rdy;
      #1;
      if (in_rdy !== irdy_early) check("rnd_in_rdy_comb", {7'd0, in_rdy}, {7'd0, irdy_early});
      out_rdy = ~out_rdy;
      @(posedge clk);
      if (ox && q.size() > 0) void'(q.pop_front());
      if (ix) q.push_back(in_dat);
      #1;
      check("rnd_out_vld", {7'd0, out_vld}, {7'd0, (q.size() > 0)});
      check("rnd_in_rdy",  {7'd0, in_rdy},  {7'd0, (q.size() < 2)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
